// File: rtl/axi4_rw_grant_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_arb_pkg
// Purpose  : Shared select encodings and channel state type for the
//            two-master AXI4 read/write grant arbiter.
// Contents : SEL_R_* read-select codes, SEL_W_* write-select codes,
//            chan_state_t channel FSM states, beat-counter sizing.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_arb_pkg;

    // Read select has no idle code: it always points at one master.
    localparam logic       SEL_R_M1   = 1'b1;
    localparam logic       SEL_R_M2   = 1'b0;

    // Write select parks on NONE whenever no write burst is in flight.
    localparam logic [2:0] SEL_W_NONE = 3'b000;
    localparam logic [2:0] SEL_W_M2   = 3'b010;
    localparam logic [2:0] SEL_W_M1   = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } chan_state_t;

    // A 4-bit LEN allows at most 16 beats; one extra code value is enough
    // to remember that a burst ran past 16 beats.
    localparam int         BEAT_W   = 5;
    localparam logic [4:0] BEAT_MAX = 5'd16;

endpackage
`default_nettype wire

// File: rtl/axi4_rw_grant_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_rw_grant_arbiter_if
// Purpose  : Bundles the request, slave-handshake and select/status signals
//            of the AXI4 read/write grant arbiter.
// Modports : slave  - the arbiter (consumes requests/handshakes, drives
//                     selects and status pulses)
//            master - the surrounding interconnect / environment
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_rw_grant_arbiter_if;

    // Master requests
    logic       M1_ARVALID;
    logic [3:0] M1_ARLEN;
    logic       M2_ARVALID;
    logic [3:0] M2_ARLEN;
    logic       M1_AWVALID;
    logic [3:0] M1_AWLEN;
    logic       M2_AWVALID;
    logic [3:0] M2_AWLEN;

    // Slave-side handshakes (after the interconnect mux)
    logic       S_ARVALID;
    logic       S_ARREADY;
    logic       S_RVALID;
    logic       S_RLAST;
    logic       S_AWREADY;
    logic       S_WREADY;
    logic       S_WLAST;

    // Selects and status
    logic       state_r;
    logic [2:0] state_w;
    logic       rd_busy;
    logic       wr_busy;
    logic       rd_len_err;
    logic       wr_len_err;
    logic       rd_timeout;
    logic       wr_timeout;

    modport slave (
        input  M1_ARVALID, M1_ARLEN, M2_ARVALID, M2_ARLEN,
        input  M1_AWVALID, M1_AWLEN, M2_AWVALID, M2_AWLEN,
        input  S_ARVALID, S_ARREADY, S_RVALID, S_RLAST,
        input  S_AWREADY, S_WREADY, S_WLAST,
        output state_r, state_w, rd_busy, wr_busy,
        output rd_len_err, wr_len_err, rd_timeout, wr_timeout
    );

    modport master (
        output M1_ARVALID, M1_ARLEN, M2_ARVALID, M2_ARLEN,
        output M1_AWVALID, M1_AWLEN, M2_AWVALID, M2_AWLEN,
        output S_ARVALID, S_ARREADY, S_RVALID, S_RLAST,
        output S_AWREADY, S_WREADY, S_WLAST,
        input  state_r, state_w, rd_busy, wr_busy,
        input  rd_len_err, wr_len_err, rd_timeout, wr_timeout
    );

endinterface
`default_nettype wire

// File: rtl/axi4_rr_chan_arb.sv
`default_nettype none
// ============================================================================
// Module   : axi4_rr_chan_arb
// Purpose  : One arbitration channel (read or write): round-robin grant
//            between two masters, burst hold from address handshake to last
//            beat, burst-length checking and a stall timeout.
// Ports    : clk, rst            clock, synchronous active-high reset
//            i_req_m1/m2         address-valid requests
//            i_len_m1/m2         burst lengths (beats-1)
//            i_addr_hs           address handshake on the slave side
//            i_beat, i_last      data beat accepted / last beat
//            o_grant_m1          registered grant (1 = M1, 0 = M2)
//            o_busy              burst in progress (ADDR or DATA)
//            o_len_err           1-cycle pulse: beat count mismatch at LAST
//            o_timeout           1-cycle pulse: grant forcibly released
// Revision : 1.0 - initial release
// ============================================================================
module axi4_rr_chan_arb
    import axi4_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11,
    parameter bit LEAK_EN     = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_req_m1,
    input  wire logic       i_req_m2,
    input  wire logic [3:0] i_len_m1,
    input  wire logic [3:0] i_len_m2,
    input  wire logic       i_addr_hs,
    input  wire logic       i_beat,
    input  wire logic       i_last,
    output logic            o_grant_m1,
    output logic            o_busy,
    output logic            o_len_err,
    output logic            o_timeout
);

    localparam int c_TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    chan_state_t       r_state;
    logic              r_grant_m1;
    logic              r_last_m1;
    logic [3:0]        r_len;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [CNT_W-1:0]  r_to_cnt;
    logic              r_len_err;
    logic              r_timeout;

    logic              w_win_m1;
    logic              w_progress;
    logic              w_to_hit;
    logic [BEAT_W-1:0] w_beat_inc;
    logic              w_len_mismatch;

    // On a tie the master that was not served last wins.
    assign w_win_m1   = i_req_m1 & (~i_req_m2 | ~r_last_m1);
    assign w_progress = i_addr_hs | i_beat;
    assign w_to_hit   = (TIMEOUT_CYC != 0) && !w_progress &&
                        (r_to_cnt == CNT_W'(c_TO_LAST));
    assign w_beat_inc = (r_beat_cnt == BEAT_MAX) ? BEAT_MAX
                                                 : r_beat_cnt + 5'd1;
    // r_beat_cnt holds the beats before the LAST beat, so the burst is
    // correct exactly when it equals LEN. A saturated count (16) can never
    // equal a 4-bit LEN, which makes overflow always an error.
    assign w_len_mismatch = (r_beat_cnt != {1'b0, r_len});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant_m1 <= SEL_R_M2;
            r_last_m1  <= 1'b0;
            r_len      <= 4'd0;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
            r_len_err  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_len_err <= 1'b0;
            r_timeout <= 1'b0;

            case (r_state)
                IDLE: begin
                    // The held grant already routes that master's address
                    // valid to the slave; a handshake here means that
                    // master owns the burst, ahead of any arbitration.
                    if (LEAK_EN && i_addr_hs) begin
                        r_state    <= DATA;
                        r_len      <= r_grant_m1 ? i_len_m1 : i_len_m2;
                        r_beat_cnt <= '0;
                    end else if (i_req_m1 | i_req_m2) begin
                        r_state    <= ADDR;
                        r_grant_m1 <= w_win_m1;
                        r_len      <= w_win_m1 ? i_len_m1 : i_len_m2;
                    end
                end
                ADDR: begin
                    if (i_addr_hs) begin
                        r_state    <= DATA;
                        r_beat_cnt <= '0;
                    end else if (w_to_hit) begin
                        r_state   <= IDLE;
                        r_last_m1 <= r_grant_m1;
                        r_timeout <= 1'b1;
                    end
                end
                DATA: begin
                    if (i_beat) begin
                        r_beat_cnt <= w_beat_inc;
                        if (i_last) begin
                            r_len_err <= w_len_mismatch;
                            r_last_m1 <= r_grant_m1;
                            r_state   <= IDLE;
                        end
                    end else if (w_to_hit) begin
                        r_state   <= IDLE;
                        r_last_m1 <= r_grant_m1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Stall counter: only runs while a burst waits for progress.
            if ((r_state == IDLE) || w_progress || w_to_hit) begin
                r_to_cnt <= '0;
            end else if (TIMEOUT_CYC != 0) begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end
        end
    end

    assign o_grant_m1 = r_grant_m1;
    assign o_busy     = (r_state != IDLE);
    assign o_len_err  = r_len_err;
    assign o_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: rtl/axi4_rw_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_rw_grant_arbiter
// Purpose  : Control stage for the two-master/one-slave AXI4 interconnect
//            mux. Arbitrates read and write channels independently and
//            produces the mux selects state_r / state_w, plus busy,
//            length-error and timeout status.
// Ports    : clk   single clock, posedge
//            rst   synchronous active-high reset
//            bus   axi4_rw_grant_arbiter_if.slave: master requests, slave
//                  handshakes, selects state_r/state_w, rd/wr busy,
//                  rd/wr_len_err and rd/wr_timeout pulses
// Revision : 1.0 - initial release
// ============================================================================
module axi4_rw_grant_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 11
) (
    input  wire logic               clk,
    input  wire logic               rst,
    axi4_rw_grant_arbiter_if.slave  bus
);

    logic w_ar_hs;
    logic w_aw_hs;
    logic w_rd_grant_m1;
    logic w_wr_grant_m1;
    logic w_wr_busy;

    assign w_ar_hs = bus.S_ARVALID & bus.S_ARREADY;
    // No muxed AWVALID comes back from the interconnect, so the write
    // address handshake is rebuilt from the granted master's AWVALID.
    assign w_aw_hs = (w_wr_grant_m1 ? bus.M1_AWVALID : bus.M2_AWVALID) &
                     bus.S_AWREADY;

    axi4_rr_chan_arb #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W),
        .LEAK_EN     (1'b1)
    ) u_rd_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_m1   (bus.M1_ARVALID),
        .i_req_m2   (bus.M2_ARVALID),
        .i_len_m1   (bus.M1_ARLEN),
        .i_len_m2   (bus.M2_ARLEN),
        .i_addr_hs  (w_ar_hs),
        .i_beat     (bus.S_RVALID),
        .i_last     (bus.S_RLAST),
        .o_grant_m1 (w_rd_grant_m1),
        .o_busy     (bus.rd_busy),
        .o_len_err  (bus.rd_len_err),
        .o_timeout  (bus.rd_timeout)
    );

    // Write select parks on NONE while idle, so no leak path exists.
    axi4_rr_chan_arb #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W),
        .LEAK_EN     (1'b0)
    ) u_wr_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req_m1   (bus.M1_AWVALID),
        .i_req_m2   (bus.M2_AWVALID),
        .i_len_m1   (bus.M1_AWLEN),
        .i_len_m2   (bus.M2_AWLEN),
        .i_addr_hs  (w_aw_hs),
        .i_beat     (bus.S_WREADY),
        .i_last     (bus.S_WLAST),
        .o_grant_m1 (w_wr_grant_m1),
        .o_busy     (w_wr_busy),
        .o_len_err  (bus.wr_len_err),
        .o_timeout  (bus.wr_timeout)
    );

    assign bus.wr_busy = w_wr_busy;
    assign bus.state_r = w_rd_grant_m1 ? SEL_R_M1 : SEL_R_M2;
    assign bus.state_w = !w_wr_busy    ? SEL_W_NONE :
                         w_wr_grant_m1 ? SEL_W_M1   : SEL_W_M2;

endmodule
`default_nettype wire

// File: tb/tb_axi4_rw_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_rw_grant_arbiter
// Purpose  : Self-checking bench for axi4_rw_grant_arbiter: directed
//            scenarios plus randomized traffic against a burst-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_rw_grant_arbiter;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_rw_grant_arbiter_if bus ();

    axi4_rw_grant_arbiter #(
        .TIMEOUT_CYC (TO),
        .CNT_W       (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Burst-level model, index 0 = read channel, 1 = write channel.
    // phase: 0 no burst, 1 waiting for address, 2 transferring data.
    // owner/prev: master number 1 or 2. beats is an unbounded count.
    int m_phase [2];
    int m_owner [2];
    int m_prev  [2];
    int m_len   [2];
    int m_beats [2];
    int m_stall [2];
    bit m_err   [2];
    bit m_to    [2];

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_phase[ch] = 0; m_owner[ch] = 2; m_prev[ch] = 2;
            m_len[ch] = 0;   m_beats[ch] = 0; m_stall[ch] = 0;
            m_err[ch] = 0;   m_to[ch] = 0;
        end
    endtask

    task automatic chan_step(input int ch, input bit r1, input bit r2,
                             input int l1, input int l2, input bit hs,
                             input bit beat, input bit last, input bit leak);
        m_err[ch] = 0;
        m_to[ch]  = 0;
        case (m_phase[ch])
            0: begin
                if (leak && hs) begin
                    m_phase[ch] = 2;
                    m_len[ch]   = (m_owner[ch] == 1) ? l1 : l2;
                    m_beats[ch] = 0;
                end else if (r1 || r2) begin
                    if (r1 && r2) m_owner[ch] = (m_prev[ch] == 1) ? 2 : 1;
                    else          m_owner[ch] = r1 ? 1 : 2;
                    m_len[ch]   = (m_owner[ch] == 1) ? l1 : l2;
                    m_phase[ch] = 1;
                end
                m_stall[ch] = 0;
            end
            1: begin
                if (hs) begin
                    m_phase[ch] = 2; m_beats[ch] = 0; m_stall[ch] = 0;
                end else if (beat) m_stall[ch] = 0;
                else               m_stall[ch]++;
            end
            default: begin
                if (beat) begin
                    m_beats[ch]++;
                    m_stall[ch] = 0;
                    if (last) begin
                        m_err[ch]   = (m_beats[ch] != m_len[ch] + 1);
                        m_prev[ch]  = m_owner[ch];
                        m_phase[ch] = 0;
                    end
                end else if (hs) m_stall[ch] = 0;
                else             m_stall[ch]++;
            end
        endcase
        if (m_phase[ch] != 0 && m_stall[ch] >= TO) begin
            m_phase[ch] = 0; m_prev[ch] = m_owner[ch];
            m_to[ch] = 1;    m_stall[ch] = 0;
        end
    endtask

    task automatic model_step();
        bit ar_hs, aw_hs;
        if (rst) begin
            model_reset();
        end else begin
            ar_hs = bus.S_ARVALID && bus.S_ARREADY;
            aw_hs = ((m_owner[1] == 1) ? bus.M1_AWVALID : bus.M2_AWVALID)
                    && bus.S_AWREADY;
            chan_step(0, bus.M1_ARVALID, bus.M2_ARVALID, int'(bus.M1_ARLEN),
                      int'(bus.M2_ARLEN), ar_hs, bus.S_RVALID, bus.S_RLAST, 1'b1);
            chan_step(1, bus.M1_AWVALID, bus.M2_AWVALID, int'(bus.M1_AWLEN),
                      int'(bus.M2_AWLEN), aw_hs, bus.S_WREADY, bus.S_WLAST, 1'b0);
        end
    endtask

    function automatic logic [9:0] exp_vec();
        logic       sr;
        logic [2:0] sw;
        sr = (m_owner[0] == 1);
        if (m_phase[1] == 0)       sw = 3'b000;
        else if (m_owner[1] == 1)  sw = 3'b011;
        else                       sw = 3'b010;
        return {sr, sw, m_phase[0] != 0, m_phase[1] != 0,
                m_err[0], m_err[1], m_to[0], m_to[1]};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {bus.state_r, bus.state_w, bus.rd_busy, bus.wr_busy,
                bus.rd_len_err, bus.wr_len_err, bus.rd_timeout, bus.wr_timeout};
    endfunction

    // One clock: the muxed ARVALID is the interconnect's view of the current
    // read select, the model advances, then outputs settle just after the edge.
    task automatic tick();
        bus.S_ARVALID = (m_owner[0] == 1) ? bus.M1_ARVALID : bus.M2_ARVALID;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.M1_ARVALID = 0; bus.M1_ARLEN = 0; bus.M2_ARVALID = 0; bus.M2_ARLEN = 0;
        bus.M1_AWVALID = 0; bus.M1_AWLEN = 0; bus.M2_AWVALID = 0; bus.M2_AWLEN = 0;
        bus.S_ARVALID = 0; bus.S_ARREADY = 0; bus.S_RVALID = 0; bus.S_RLAST = 0;
        bus.S_AWREADY = 0; bus.S_WREADY = 0; bus.S_WLAST = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec() !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_state: got %b required %b", dut_vec(), 10'b0);
        end
    endtask

    task automatic test_read_single();
        do_reset();
        bus.M1_ARVALID = 1; bus.M1_ARLEN = 4'd3;
        tick();
        n_checks++;
        if (bus.state_r !== 1'b1 || bus.rd_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_grant: state_r=%b rd_busy=%b required 1 1", bus.state_r, bus.rd_busy);
        end
        bus.S_ARREADY = 1;
        tick();
        bus.M1_ARVALID = 0; bus.S_ARREADY = 0;
        for (int i = 0; i < 4; i++) begin
            bus.S_RVALID = 1; bus.S_RLAST = (i == 3);
            tick();
            n_checks++;
            if (i < 3 && (bus.state_r !== 1'b1 || bus.rd_busy !== 1'b1)) begin
                n_fail++;
                $display("FAIL rd_beat%0d: state_r=%b rd_busy=%b required 1 1", i, bus.state_r, bus.rd_busy);
            end else if (i == 3 && (bus.state_r !== 1'b1 || bus.rd_busy !== 1'b0 || bus.rd_len_err !== 1'b0)) begin
                n_fail++;
                $display("FAIL rd_last: state_r=%b rd_busy=%b rd_len_err=%b required 1 0 0",
                         bus.state_r, bus.rd_busy, bus.rd_len_err);
            end
        end
        bus.S_RVALID = 0; bus.S_RLAST = 0;
    endtask

    task automatic test_write_tie();
        do_reset();
        bus.M1_AWVALID = 1; bus.M2_AWVALID = 1; bus.M1_AWLEN = 4'd1; bus.M2_AWLEN = 4'd1;
        tick();
        n_checks++;
        if (bus.state_w !== 3'b011) begin
            n_fail++;
            $display("FAIL wr_tie_m1: state_w=%b required 011", bus.state_w);
        end
        bus.S_AWREADY = 1; tick();
        bus.M1_AWVALID = 0; bus.S_AWREADY = 0;
        for (int i = 0; i < 2; i++) begin
            bus.S_WREADY = 1; bus.S_WLAST = (i == 1); tick();
        end
        n_checks++;
        if (bus.state_w !== 3'b000 || bus.wr_len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_end_bubble: state_w=%b wr_len_err=%b required 000 0", bus.state_w, bus.wr_len_err);
        end
        bus.S_WREADY = 0; bus.S_WLAST = 0;
        tick();
        n_checks++;
        if (bus.state_w !== 3'b010) begin
            n_fail++;
            $display("FAIL wr_then_m2: state_w=%b required 010", bus.state_w);
        end
        bus.S_AWREADY = 1; tick();
        bus.M2_AWVALID = 0; bus.S_AWREADY = 0;
        for (int i = 0; i < 2; i++) begin
            bus.S_WREADY = 1; bus.S_WLAST = (i == 1); tick();
        end
        n_checks++;
        if (bus.wr_busy !== 1'b0 || bus.wr_len_err !== 1'b0 || bus.state_w !== 3'b000) begin
            n_fail++;
            $display("FAIL wr_m2_done: wr_busy=%b wr_len_err=%b state_w=%b required 0 0 000",
                     bus.wr_busy, bus.wr_len_err, bus.state_w);
        end
        bus.S_WREADY = 0; bus.S_WLAST = 0;
    endtask

    task automatic test_read_leak();
        do_reset();
        bus.M2_ARVALID = 1; bus.M2_ARLEN = 4'd1; bus.S_ARREADY = 1;
        tick();
        n_checks++;
        if (bus.state_r !== 1'b0 || bus.rd_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL leak_grant: state_r=%b rd_busy=%b required 0 1", bus.state_r, bus.rd_busy);
        end
        bus.M2_ARVALID = 0; bus.S_ARREADY = 0;
        bus.S_RVALID = 1; tick();
        bus.S_RLAST = 1; tick();
        n_checks++;
        if (bus.rd_busy !== 1'b0 || bus.rd_len_err !== 1'b0 || bus.state_r !== 1'b0) begin
            n_fail++;
            $display("FAIL leak_done: rd_busy=%b rd_len_err=%b state_r=%b required 0 0 0",
                     bus.rd_busy, bus.rd_len_err, bus.state_r);
        end
        bus.S_RVALID = 0; bus.S_RLAST = 0;
    endtask

    // Grants M1 a read of arlen, then delivers nbeats with RLAST on the last.
    task automatic run_read(input int arlen, input int nbeats, output bit err, output bit busy);
        do_reset();
        bus.M1_ARVALID = 1; bus.M1_ARLEN = 4'(arlen);
        tick();
        bus.S_ARREADY = 1; tick();
        bus.M1_ARVALID = 0; bus.S_ARREADY = 0;
        for (int i = 0; i < nbeats; i++) begin
            bus.S_RVALID = 1; bus.S_RLAST = (i == nbeats - 1); tick();
        end
        err = bus.rd_len_err; busy = bus.rd_busy;
        bus.S_RVALID = 0; bus.S_RLAST = 0;
    endtask

    task automatic test_len_err();
        bit err, busy;
        run_read(3, 2, err, busy);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len_short: rd_len_err=%b rd_busy=%b required 1 0", err, busy);
        end
        tick();
        n_checks++;
        if (bus.rd_len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL len_pulse_width: rd_len_err=%b required 0", bus.rd_len_err);
        end
        run_read(15, 16, err, busy);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len_16_exact: rd_len_err=%b rd_busy=%b required 0 0", err, busy);
        end
        run_read(15, 17, err, busy);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL len_overflow: rd_len_err=%b required 1", err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.M1_AWVALID = 1; bus.M2_AWVALID = 1;
        tick();
        for (int i = 1; i <= TO; i++) begin
            tick();
            n_checks++;
            if (i < TO && (bus.wr_timeout !== 1'b0 || bus.state_w !== 3'b011)) begin
                n_fail++;
                $display("FAIL to_wait%0d: wr_timeout=%b state_w=%b required 0 011", i, bus.wr_timeout, bus.state_w);
            end else if (i == TO && (bus.wr_timeout !== 1'b1 || bus.state_w !== 3'b000 || bus.wr_busy !== 1'b0)) begin
                n_fail++;
                $display("FAIL to_fire: wr_timeout=%b state_w=%b wr_busy=%b required 1 000 0",
                         bus.wr_timeout, bus.state_w, bus.wr_busy);
            end
        end
        tick();
        n_checks++;
        if (bus.state_w !== 3'b010 || bus.wr_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL to_rearb: state_w=%b wr_timeout=%b required 010 0", bus.state_w, bus.wr_timeout);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.M1_ARVALID = 1; bus.M1_ARLEN = 4'd3; bus.M2_AWVALID = 1; bus.M2_AWLEN = 4'd3;
        tick();
        bus.S_ARREADY = 1; bus.S_AWREADY = 1; tick();
        clear_inputs();
        bus.S_RVALID = 1; bus.S_WREADY = 1; tick();
        n_checks++;
        if (dut_vec() !== 10'b1_010_11_0000) begin
            n_fail++;
            $display("FAIL mid_burst_pre: got %b required %b", dut_vec(), 10'b1_010_11_0000);
        end
        bus.S_RLAST = 1; bus.S_WLAST = 1; rst = 1;
        tick();
        n_checks++;
        if (dut_vec() !== 10'b0) begin
            n_fail++;
            $display("FAIL mid_burst_rst: got %b required %b", dut_vec(), 10'b0);
        end
        rst = 0; clear_inputs(); tick();
    endtask

    task automatic test_random();
        int last_div;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            last_div = (c < 1500) ? 3 : 40;
            rst            = ($urandom_range(0, 299) == 0);
            bus.M1_ARVALID = ($urandom_range(0, 2) == 0);
            bus.M2_ARVALID = ($urandom_range(0, 2) == 0);
            bus.M1_AWVALID = ($urandom_range(0, 2) == 0);
            bus.M2_AWVALID = ($urandom_range(0, 2) == 0);
            bus.M1_ARLEN   = 4'($urandom_range(0, 3));
            bus.M2_ARLEN   = 4'($urandom_range(0, 15));
            bus.M1_AWLEN   = 4'($urandom_range(0, 15));
            bus.M2_AWLEN   = 4'($urandom_range(0, 3));
            bus.S_ARREADY  = ($urandom_range(0, 3) == 0);
            bus.S_AWREADY  = ($urandom_range(0, 3) == 0);
            bus.S_RVALID   = ($urandom_range(0, 1) == 0);
            bus.S_RLAST    = bus.S_RVALID && ($urandom_range(0, last_div - 1) == 0);
            bus.S_WREADY   = ($urandom_range(0, 1) == 0);
            bus.S_WLAST    = bus.S_WREADY && ($urandom_range(0, last_div - 1) == 0);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %b required %b", c, dut_vec(), exp_vec());
            end
        end
        rst = 0;
    endtask

    initial begin
        model_reset();
        clear_inputs();
        test_reset();
        test_read_single();
        test_write_tie();
        test_read_leak();
        test_len_err();
        test_timeout();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
